// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types and sizing constants for the MAC tile sequencer.
package mac_seq_pkg;

    localparam int NB_TAPS_DEF  = 18;
    localparam int NB_BEATS_DEF = 9;
    localparam int MAC_SEL_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mac_seq_issue.sv
// mac_seq_issue: tap issue counter plus the one-cycle delay that lines the MAC
// controls up with the kernel SRAM read latency.
//  - stage 1 drives kernel_re / kernel address for NB_TAPS consecutive cycles
//  - stage 2 replays stage 1 one cycle later as mac_valid / select / accumulate
//  - output_we follows the final mac_valid by one cycle
module mac_seq_issue
    import mac_seq_pkg::*;
#(
    parameter int NB_TAPS       = NB_TAPS_DEF,
    parameter int KERNEL_HEIGHT = 128
) (
    input  logic                             clk,
    input  logic                             arst_n_in,
    input  logic                             i_launch,
    input  logic [$clog2(KERNEL_HEIGHT)-1:0] i_base,
    output logic                             o_kernel_re,
    output logic [$clog2(KERNEL_HEIGHT)-1:0] o_kernel_addr,
    output logic                             o_last_issue,
    output logic                             o_busy,
    output logic                             o_mac_valid,
    output logic [MAC_SEL_W-1:0]             o_mac_sel,
    output logic                             o_mac_acc,
    output logic                             o_output_we
);

    localparam int ADDR_W = $clog2(KERNEL_HEIGHT);
    localparam int TAP_W  = $clog2(NB_TAPS);

    localparam logic [TAP_W-1:0]     TAP_LAST  = TAP_W'(NB_TAPS - 1);
    localparam logic [ADDR_W-1:0]    ADDR_LAST = ADDR_W'(KERNEL_HEIGHT - 1);
    localparam logic [MAC_SEL_W-1:0] SEL_LAST  = MAC_SEL_W'(NB_TAPS - 1);

    logic                 r_re;
    logic [TAP_W-1:0]     r_tap;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_mv;
    logic [MAC_SEL_W-1:0] r_sel;
    logic                 r_acc;
    logic                 r_owe;

    logic                 w_tap_last;
    logic [ADDR_W-1:0]    w_addr_next;

    assign w_tap_last  = r_re && (r_tap == TAP_LAST);
    // Wrap explicitly so non-power-of-two kernel depths also roll over to 0.
    assign w_addr_next = (r_addr == ADDR_LAST) ? '0 : r_addr + ADDR_W'(1);

    // Stage 1: tap counter and kernel read address; address parks at 0 when idle.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_re   <= 1'b0;
            r_tap  <= '0;
            r_addr <= '0;
        end else if (i_launch) begin
            r_re   <= 1'b1;
            r_tap  <= '0;
            r_addr <= i_base;
        end else if (w_tap_last) begin
            r_re   <= 1'b0;
            r_tap  <= '0;
            r_addr <= '0;
        end else if (r_re) begin
            r_tap  <= r_tap + TAP_W'(1);
            r_addr <= w_addr_next;
        end
    end

    // Stage 2: MAC controls trail the SRAM read by one cycle; select holds when idle.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_mv  <= 1'b0;
            r_sel <= '0;
            r_acc <= 1'b0;
            r_owe <= 1'b0;
        end else begin
            r_mv  <= r_re;
            r_acc <= r_re && (r_tap != '0);
            r_owe <= r_mv && (r_sel == SEL_LAST);
            if (r_re) begin
                r_sel <= MAC_SEL_W'(r_tap);
            end
        end
    end

    assign o_kernel_re   = r_re;
    assign o_kernel_addr = r_addr;
    assign o_last_issue  = w_tap_last;
    assign o_busy        = r_re | r_mv;
    assign o_mac_valid   = r_mv;
    assign o_mac_sel     = r_sel;
    assign o_mac_acc     = r_acc;
    assign o_output_we   = r_owe;

endmodule

// File: rtl/mac_tile_sequencer.sv
// mac_tile_sequencer: loads feature beats into the Next_Feature prefetch buffer,
// copies it to Feature, and issues one kernel tap per cycle for every tile.
// Build macro MAC_SEQ_STALL_CNT_EN adds the prefetch-underrun counter on
// stall_cycles; without it stall_cycles is tied to 0.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | loading the first tile, nothing issued yet
// RUN   | issuing taps, prefetching the following tile in parallel
// FLUSH | last tap issued, waiting for the final output_we
module mac_tile_sequencer
    import mac_seq_pkg::*;
#(
    parameter int NB_TAPS       = NB_TAPS_DEF,
    parameter int KERNEL_HEIGHT = 128,
    parameter int TILE_CNT_W    = 16
) (
    input  logic                             clk,
    input  logic                             arst_n_in,
    input  logic                             start,
    input  logic [TILE_CNT_W-1:0]            tile_count,
    input  logic [$clog2(KERNEL_HEIGHT)-1:0] kernel_base,
    output logic                             running,
    output logic                             done,
    input  logic                             a_valid,
    output logic                             a_ready,
    output logic [NB_TAPS/2-1:0]             nf_we,
    output logic                             feature_we,
    output logic                             kernel_re,
    output logic [$clog2(KERNEL_HEIGHT)-1:0] kernel_read_addr,
    output logic [MAC_SEL_W-1:0]             mux18_select,
    output logic                             mac_valid,
    output logic                             mac_accumulate_internal,
    output logic                             output_we,
    output logic [15:0]                      stall_cycles
);

    localparam int NB_BEATS = NB_TAPS / 2;
    localparam int BEAT_W   = $clog2(NB_BEATS);
    localparam int ADDR_W   = $clog2(KERNEL_HEIGHT);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NB_BEATS - 1);

    seq_state_e            r_state;
    seq_state_e            w_state_next;

    logic [ADDR_W-1:0]     r_kernel_base;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic                  r_buf_full;
    logic [TILE_CNT_W-1:0] r_load_left;
    logic [TILE_CNT_W-1:0] r_issue_left;
    logic                  r_zero_done;

    logic                  w_start_acc;
    logic                  w_fill_or_run;
    logic                  w_beat_acc;
    logic                  w_final_beat;
    logic                  w_feature_we;
    logic                  w_busy;
    logic                  w_last_issue;
    logic                  w_output_we;

    assign w_start_acc   = (r_state == IDLE) && start;
    assign w_fill_or_run = (r_state == FILL) || (r_state == RUN);
    assign a_ready       = w_fill_or_run && !r_buf_full && (r_load_left != '0);
    assign w_beat_acc    = a_valid && a_ready;
    assign w_final_beat  = w_beat_acc && (r_beat_cnt == BEAT_LAST);
    assign nf_we         = w_beat_acc ? (NB_BEATS'(1) << r_beat_cnt) : '0;
    // The copy waits for the previous tile's last MAC so Feature is never
    // overwritten under a tap still in flight.
    assign w_feature_we  = w_fill_or_run && r_buf_full && !w_busy;
    assign feature_we    = w_feature_we;

    assign running = (r_state != IDLE);
    assign done    = r_zero_done | ((r_state == FLUSH) && w_output_we);

    // State register.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start && (tile_count != '0)) begin
                    w_state_next = FILL;
                end
            end
            FILL: begin
                if (r_buf_full) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last_issue && (r_issue_left == '0)) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (w_output_we) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Job bookkeeping: tiles left to load / issue count down to zero, the beat
    // index walks the Next_Feature pairs, and the buffer flag spans final beat
    // to feature copy.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_kernel_base <= '0;
            r_beat_cnt    <= '0;
            r_buf_full    <= 1'b0;
            r_load_left   <= '0;
            r_issue_left  <= '0;
            r_zero_done   <= 1'b0;
        end else if (w_start_acc) begin
            r_kernel_base <= kernel_base;
            r_beat_cnt    <= '0;
            r_buf_full    <= 1'b0;
            r_load_left   <= tile_count;
            r_issue_left  <= tile_count;
            r_zero_done   <= (tile_count == '0);
        end else begin
            r_zero_done <= 1'b0;
            if (w_final_beat) begin
                r_beat_cnt  <= '0;
                r_buf_full  <= 1'b1;
                r_load_left <= r_load_left - TILE_CNT_W'(1);
            end else if (w_beat_acc) begin
                r_beat_cnt  <= r_beat_cnt + BEAT_W'(1);
            end else if (w_feature_we) begin
                r_buf_full   <= 1'b0;
                r_issue_left <= r_issue_left - TILE_CNT_W'(1);
            end
        end
    end

    mac_seq_issue #(
        .NB_TAPS       (NB_TAPS),
        .KERNEL_HEIGHT (KERNEL_HEIGHT)
    ) u_issue (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .i_launch      (w_feature_we),
        .i_base        (r_kernel_base),
        .o_kernel_re   (kernel_re),
        .o_kernel_addr (kernel_read_addr),
        .o_last_issue  (w_last_issue),
        .o_busy        (w_busy),
        .o_mac_valid   (mac_valid),
        .o_mac_sel     (mux18_select),
        .o_mac_acc     (mac_accumulate_internal),
        .o_output_we   (w_output_we)
    );

    assign output_we = w_output_we;

`ifdef MAC_SEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    // A tile is due for issue but its beats have not all arrived.
    assign w_stall = w_fill_or_run && !w_busy && !r_buf_full && (r_issue_left != '0);

    // Saturating underrun counter, cleared when a job is accepted.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// tb_mac_tile_sequencer: randomized stimulus against a tile-level timing model.
// The model tracks beats, tiles loaded/issued and the cycle of each feature copy;
// every output is then derived from the offset to the latest copy.
module tb_mac_tile_sequencer;

    localparam int KH  = 128;
    localparam int NT  = 18;
    localparam int NBT = 9;
`ifdef MAC_SEQ_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        start;
    logic [15:0] tile_count;
    logic [6:0]  kernel_base;
    logic        running;
    logic        done;
    logic        a_valid;
    logic        a_ready;
    logic [8:0]  nf_we;
    logic        feature_we;
    logic        kernel_re;
    logic [6:0]  kernel_read_addr;
    logic [4:0]  mux18_select;
    logic        mac_valid;
    logic        mac_accumulate_internal;
    logic        output_we;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    mac_tile_sequencer dut (
        .clk                     (clk),
        .arst_n_in               (arst_n_in),
        .start                   (start),
        .tile_count              (tile_count),
        .kernel_base             (kernel_base),
        .running                 (running),
        .done                    (done),
        .a_valid                 (a_valid),
        .a_ready                 (a_ready),
        .nf_we                   (nf_we),
        .feature_we              (feature_we),
        .kernel_re               (kernel_re),
        .kernel_read_addr        (kernel_read_addr),
        .mux18_select            (mux18_select),
        .mac_valid               (mac_valid),
        .mac_accumulate_internal (mac_accumulate_internal),
        .output_we               (output_we),
        .stall_cycles            (stall_cycles)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit m_active;
    bit m_full;
    int m_n, m_base, m_beats, m_loaded, m_issued, m_fw, m_zero_cyc, m_stall, m_sel;

    logic [44:0] x_obs, x_exp;
    bit          e_done;

    function automatic logic [44:0] sample_obs();
        return {running, done, a_ready, nf_we, feature_we, kernel_re, kernel_read_addr,
                mux18_select, mac_valid, mac_accumulate_internal, output_we, stall_cycles};
    endfunction

    task automatic model_reset();
        m_active = 0; m_full = 0; m_n = 0; m_base = 0; m_beats = 0; m_loaded = 0;
        m_issued = 0; m_fw = -1000; m_zero_cyc = -1; m_stall = 0; m_sel = 0;
    endtask

    // One clock: drive inputs after the edge, sample at the falling edge, advance the model.
    task automatic step(input bit av, input bit st, input int tc, input int kb);
        int d, addr;
        bit re, mv, owe, busy, rdy, fw, dn, acc, take;
        logic [8:0]  nf;
        logic [15:0] stl;
        @(posedge clk); #1;
        a_valid = av; start = st; tile_count = 16'(tc); kernel_base = 7'(kb);
        @(negedge clk);
        cyc++;
        d    = cyc - m_fw;
        re   = m_active && d >= 1 && d <= NT;
        mv   = m_active && d >= 2 && d <= NT + 1;
        owe  = m_active && d == NT + 2;
        busy = m_active && d >= 1 && d <= NT + 1;
        rdy  = m_active && !m_full && m_loaded < m_n;
        fw   = m_active && m_full && !busy;
        dn   = (cyc == m_zero_cyc) || (owe && m_issued == m_n);
        addr = re ? (m_base + d - 1) % KH : 0;
        if (mv) m_sel = d - 2;
        acc  = mv && (d - 2) != 0;
        take = rdy && av;
        nf   = take ? 9'(1 << m_beats) : 9'd0;
        stl  = STALL_EN ? 16'(m_stall) : 16'd0;
        x_exp  = {m_active, dn, rdy, nf, fw, re, 7'(addr), 5'(m_sel), mv, acc, owe, stl};
        x_obs  = sample_obs();
        e_done = dn;
        if (st && !m_active) begin
            m_stall = 0;
            if (tc == 0) m_zero_cyc = cyc + 1;
            else begin
                m_active = 1; m_n = tc; m_base = kb; m_beats = 0; m_full = 0;
                m_loaded = 0; m_issued = 0; m_fw = -1000;
            end
        end else if (m_active) begin
            if (!busy && !m_full && m_issued < m_n && m_stall < 65535) m_stall++;
            if (take) begin
                m_beats++;
                if (m_beats == NBT) begin m_beats = 0; m_full = 1; m_loaded++; end
            end
            if (fw) begin m_full = 0; m_fw = cyc; m_issued++; end
            if (dn) m_active = 0;
        end
    endtask

    task automatic test_reset();
        logic [44:0] o;
        arst_n_in = 0; start = 0; a_valid = 0; tile_count = 0; kernel_base = 0;
        model_reset();
        #3;
        o = sample_obs();
        n_cmp++;
        if (o !== 45'd0) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", o); end
        @(posedge clk); #1 arst_n_in = 1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            n_cmp++;
            if (x_obs !== x_exp) begin n_bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
        end
    endtask

    task automatic test_single_tile();
        int n_re = 0, n_done = 0;
        bit fin = 0;
        step(0, 1, 1, 0);
        n_cmp++;
        if (x_obs !== x_exp) begin n_bad++; $display("FAIL single_start cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
        for (int i = 0; i < 80 && !fin; i++) begin
            step(1, 0, 0, 0);
            n_cmp++;
            if (x_obs !== x_exp) begin n_bad++; $display("FAIL single_tile cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
            if (kernel_re) n_re++;
            if (done) n_done++;
            if (e_done) fin = 1;
        end
        n_cmp++;
        if (!fin) begin n_bad++; $display("FAIL single_timeout got=running exp=done"); end
        n_cmp++;
        if (n_re != NT) begin n_bad++; $display("FAIL single_re_count got=%0d exp=%0d", n_re, NT); end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL single_done_count got=%0d exp=1", n_done); end
    endtask

    task automatic test_overlap();
        int n_owe = 0, n_fw = 0, n_ovl = 0, n_gap = 0, last_mv = -10;
        bit fin = 0;
        step(0, 1, 3, int'($urandom_range(0, KH - 1)));
        for (int i = 0; i < 150 && !fin; i++) begin
            step(1, i == 30, 5, 0);
            n_cmp++;
            if (x_obs !== x_exp) begin n_bad++; $display("FAIL overlap cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
            if (output_we) n_owe++;
            if (nf_we != 0 && kernel_re) n_ovl++;
            if (feature_we) begin
                n_fw++;
                if (cyc == last_mv + 1) n_gap++;
            end
            if (mac_valid && mux18_select == 5'(NT - 1)) last_mv = cyc;
            if (e_done) fin = 1;
        end
        n_cmp++;
        if (!fin) begin n_bad++; $display("FAIL overlap_timeout got=running exp=done"); end
        n_cmp++;
        if (n_owe != 3) begin n_bad++; $display("FAIL overlap_owe_count got=%0d exp=3", n_owe); end
        n_cmp++;
        if (n_fw != 3) begin n_bad++; $display("FAIL overlap_fw_count got=%0d exp=3", n_fw); end
        n_cmp++;
        if (n_ovl != 2 * NBT) begin n_bad++; $display("FAIL overlap_beats_during_issue got=%0d exp=%0d", n_ovl, 2 * NBT); end
        n_cmp++;
        if (n_gap != 2) begin n_bad++; $display("FAIL overlap_fw_after_last_mv got=%0d exp=2", n_gap); end
    endtask

    task automatic test_wrap();
        int addrs[NT];
        int k = 0;
        bit fin = 0;
        step(0, 1, 1, 120);
        for (int i = 0; i < 80 && !fin; i++) begin
            step(1, 0, 0, 0);
            n_cmp++;
            if (x_obs !== x_exp) begin n_bad++; $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
            if (kernel_re && k < NT) begin addrs[k] = int'(kernel_read_addr); k++; end
            if (e_done) fin = 1;
        end
        n_cmp++;
        if (k != NT) begin n_bad++; $display("FAIL wrap_count got=%0d exp=%0d", k, NT); end
        n_cmp++;
        if (addrs[0] != 120) begin n_bad++; $display("FAIL wrap_first got=%0d exp=120", addrs[0]); end
        n_cmp++;
        if (addrs[8] != 0) begin n_bad++; $display("FAIL wrap_rollover got=%0d exp=0", addrs[8]); end
        n_cmp++;
        if (addrs[NT - 1] != 9) begin n_bad++; $display("FAIL wrap_last got=%0d exp=9", addrs[NT - 1]); end
    endtask

    task automatic test_starve();
        int n_rdy = 0, n_re_win = 0;
        bit fin = 0;
        bit av;
        step(0, 1, 2, int'($urandom_range(0, KH - 1)));
        for (int i = 1; i < 200 && !fin; i++) begin
            av = (i < 10) || (i >= 40);
            step(av, 0, 0, 0);
            n_cmp++;
            if (x_obs !== x_exp) begin n_bad++; $display("FAIL starve cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
            if (!av && a_ready) n_rdy++;
            if (i >= 30 && i <= 48 && kernel_re) n_re_win++;
            if (e_done) fin = 1;
        end
        n_cmp++;
        if (!fin) begin n_bad++; $display("FAIL starve_timeout got=running exp=done"); end
        n_cmp++;
        if (n_rdy != 29) begin n_bad++; $display("FAIL starve_ready got=%0d exp=29", n_rdy); end
        n_cmp++;
        if (n_re_win != 0) begin n_bad++; $display("FAIL starve_issue_paused got=%0d exp=0", n_re_win); end
        n_cmp++;
        if (stall_cycles !== (STALL_EN ? 16'd28 : 16'd0)) begin
            n_bad++; $display("FAIL starve_stall_count got=%0d exp=%0d", stall_cycles, STALL_EN ? 28 : 0);
        end
    endtask

    task automatic test_zero_tiles();
        int n_done = 0, n_rdy = 0;
        step(0, 1, 0, 33);
        n_cmp++;
        if (x_obs !== x_exp) begin n_bad++; $display("FAIL zero_start cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            n_cmp++;
            if (x_obs !== x_exp) begin n_bad++; $display("FAIL zero_tiles cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
            if (done) n_done++;
            if (a_ready) n_rdy++;
        end
        n_cmp++;
        if (n_done != 1) begin n_bad++; $display("FAIL zero_done_count got=%0d exp=1", n_done); end
        n_cmp++;
        if (n_rdy != 0) begin n_bad++; $display("FAIL zero_ready_count got=%0d exp=0", n_rdy); end
    endtask

    task automatic test_reset_mid_run();
        logic [44:0] o;
        step(0, 1, 2, int'($urandom_range(0, KH - 1)));
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            n_cmp++;
            if (x_obs !== x_exp) begin n_bad++; $display("FAIL midrun cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
        end
        #2 arst_n_in = 0;
        #1 o = sample_obs();
        n_cmp++;
        if (o !== 45'd0) begin n_bad++; $display("FAIL midrun_reset got=%h exp=0", o); end
        model_reset();
        @(posedge clk); #1 arst_n_in = 1;
    endtask

    task automatic test_random_jobs();
        int n_done;
        bit fin;
        for (int j = 0; j < 4; j++) begin
            n_done = 0; fin = 0;
            step(0, 1, int'($urandom_range(1, 4)), int'($urandom_range(0, KH - 1)));
            n_cmp++;
            if (x_obs !== x_exp) begin n_bad++; $display("FAIL random_start cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
            for (int i = 0; i < 600 && !fin; i++) begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, int'($urandom_range(0, 7)), 5);
                n_cmp++;
                if (x_obs !== x_exp) begin n_bad++; $display("FAIL random_job cyc=%0d got=%h exp=%h", cyc, x_obs, x_exp); end
                if (done) n_done++;
                if (e_done) fin = 1;
            end
            n_cmp++;
            if (!fin || n_done != 1) begin
                n_bad++; $display("FAIL random_done job=%0d got=%0d exp=1", j, n_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_overlap();
        test_wrap();
        test_starve();
        test_zero_tiles();
        test_reset_mid_run();
        test_random_jobs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
